// File: rtl/differentiator_n_bits.sv
// Recovers addends from a running-sum stream: A = S_cur - S_prev (mod 2^N), with borrow and signed-overflow flags.
// Optional feature macro: DIFF_OVF_STICKY_EN (overflow latches until aclr or a sync sample).
module differentiator_n_bits #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic [N-1:0] S,
    input  logic         s_valid,
    input  logic         sync,
    output logic [N-1:0] A,
    output logic         a_valid,
    output logic         borrow,
    output logic         overflow,
    output logic         tracking
);

    typedef enum logic {
        ST_ZERO  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_next;

    logic [N-1:0] r_b;
    logic         r_v1;
    logic         r_y1;

    logic [N-1:0] r_p;
    logic [N-1:0] r_a;
    logic         r_a_valid;
    logic         r_borrow;
    logic         r_ovf;

    logic [N:0]   w_diff;
    logic         w_ovf;

    // Stage 1: capture the sample; B keeps its old value across idle cycles.
    always_ff @(posedge clk) begin
        if (aclr) begin
            r_b  <= '0;
            r_v1 <= 1'b0;
            r_y1 <= 1'b0;
        end else begin
            if (s_valid) begin
                r_b <= S;
            end
            r_v1 <= s_valid;
            r_y1 <= s_valid & sync;
        end
    end

    // Zero-extended subtraction: the top bit is the inverted carry, i.e. the borrow.
    assign w_diff = {1'b0, r_b} - {1'b0, r_p};
    assign w_ovf  = (r_b[N-1] != r_p[N-1]) && (w_diff[N-1] != r_b[N-1]);

    // Stage 2: emit a difference, or only reload P for a sync sample.
    always_ff @(posedge clk) begin
        if (aclr) begin
            r_p       <= '0;
            r_a       <= '0;
            r_a_valid <= 1'b0;
            r_borrow  <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_a_valid <= 1'b0;
            if (r_v1) begin
                r_p <= r_b;
                if (!r_y1) begin
                    r_a       <= w_diff[N-1:0];
                    r_borrow  <= w_diff[N];
                    r_a_valid <= 1'b1;
`ifdef DIFF_OVF_STICKY_EN
                    r_ovf     <= r_ovf | w_ovf;
`else
                    r_ovf     <= w_ovf;
`endif
                end
`ifdef DIFF_OVF_STICKY_EN
                else begin
                    r_ovf <= 1'b0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_state <= ST_ZERO;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Any stage-2 load of P, emitted or sync, leaves ZERO for good until reset.
    always_comb begin
        w_state_next = r_state;
        if (r_v1) begin
            w_state_next = ST_TRACK;
        end
    end

    assign A        = r_a;
    assign a_valid  = r_a_valid;
    assign borrow   = r_borrow;
    assign overflow = r_ovf;
    assign tracking = (r_state == ST_TRACK);

endmodule

// File: tb/tb_differentiator_n_bits.sv
// Self-checking bench for differentiator_n_bits (N=8): directed scenarios plus a randomized stream against a sample-level model.
module tb_differentiator_n_bits;

    localparam int N = 8;

`ifdef DIFF_OVF_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic         clk;
    logic         aclr;
    logic [N-1:0] S;
    logic         s_valid;
    logic         sync;
    logic [N-1:0] A;
    logic         a_valid;
    logic         borrow;
    logic         overflow;
    logic         tracking;

    differentiator_n_bits #(.N(N)) dut (
        .clk      (clk),
        .aclr     (aclr),
        .S        (S),
        .s_valid  (s_valid),
        .sync     (sync),
        .A        (A),
        .a_valid  (a_valid),
        .borrow   (borrow),
        .overflow (overflow),
        .tracking (tracking)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Observed outputs packed as {A, a_valid, borrow, overflow, tracking}.
    logic [N+3:0] obs;
    assign obs = {A, a_valid, borrow, overflow, tracking};

    // Reference model: the sample waiting one cycle, the last loaded value, and the expected outputs.
    int   m_prev;
    bit   pend_valid, pend_sync;
    int   pend_s;
    int   m_a;
    bit   m_av, m_bo, m_ov, m_tr;

    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic logic [N+3:0] model_vec();
        logic [N-1:0] a8;
        a8 = m_a[N-1:0];
        return {a8, m_av, m_bo, m_ov, m_tr};
    endfunction

    // Drive one cycle of inputs, clock it, and advance the model; outputs are sampled 1 time unit after the edge.
    task automatic step(input bit rst, input bit sv, input bit sy, input int s);
        int sd;
        aclr    = rst;
        s_valid = sv;
        sync    = sy;
        S       = s[N-1:0];
        @(posedge clk);
        if (rst) begin
            m_a = 0; m_av = 0; m_bo = 0; m_ov = 0; m_tr = 0;
            m_prev = 0; pend_valid = 0; pend_sync = 0; pend_s = 0;
        end else begin
            m_av = 0;
            if (pend_valid) begin
                m_tr = 1;
                if (pend_sync) begin
                    if (STICKY) m_ov = 0;
                end else begin
                    m_a  = (pend_s - m_prev + 256) % 256;
                    m_bo = pend_s < m_prev;
                    sd   = to_signed8(pend_s) - to_signed8(m_prev);
                    m_ov = (STICKY && m_ov) || (sd > 127) || (sd < -128);
                    m_av = 1;
                end
                m_prev = pend_s;
            end
            pend_valid = sv;
            pend_sync  = sv && sy;
            pend_s     = s % 256;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)));
            n_total++;
            if (obs !== 12'h000) $display("FAIL reset[%0d]: got %h want %h", i, obs, 12'h000);
            else n_pass++;
        end
        $display("reset: outputs %h after 2 reset edges", obs);
    endtask

    task automatic test_stream();
        int           s_tab [4] = '{5, 12, 12, 3};
        logic [N+3:0] e_tab [4] = '{{8'd5, 4'b1001}, {8'd7, 4'b1001}, {8'd0, 4'b1001}, {8'hF7, 4'b1101}};
        step(1, 0, 0, 0);
        step(0, 1, 0, s_tab[0]);
        n_total++;
        if (a_valid !== 1'b0) $display("FAIL stream_latency: a_valid got %b want 0", a_valid);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(0, 1, 0, s_tab[i+1]);
            else       step(0, 0, 0, 0);
            n_total++;
            if (obs !== e_tab[i]) $display("FAIL stream[%0d]: got %h want %h", i, obs, e_tab[i]);
            else n_pass++;
            $display("stream: A=%0d borrow=%b overflow=%b tracking=%b", A, borrow, overflow, tracking);
        end
    endtask

    task automatic test_overflow();
        logic [N+3:0] exp2;
        step(1, 0, 0, 0);
        step(0, 1, 0, 'h70);
        step(0, 1, 0, 'h90);
        step(0, 1, 0, 'h91);
        n_total++;
        if (obs !== {8'h20, 4'b1011}) $display("FAIL overflow_set: got %h want %h", obs, {8'h20, 4'b1011});
        else n_pass++;
        $display("overflow: A=%h borrow=%b overflow=%b", A, borrow, overflow);
        step(0, 0, 0, 0);
        exp2 = {8'h01, 1'b1, 1'b0, STICKY, 1'b1};
        n_total++;
        if (obs !== exp2) $display("FAIL overflow_next: got %h want %h", obs, exp2);
        else n_pass++;
        $display("overflow: A=%h borrow=%b overflow=%b", A, borrow, overflow);
    endtask

    task automatic test_sync();
        step(1, 0, 0, 0);
        step(0, 1, 1, 100);
        n_total++;
        if (obs !== 12'h000) $display("FAIL sync_pre: got %h want %h", obs, 12'h000);
        else n_pass++;
        step(0, 1, 0, 103);
        n_total++;
        if (obs !== 12'h001) $display("FAIL sync_load: got %h want %h", obs, 12'h001);
        else n_pass++;
        step(0, 0, 0, 0);
        n_total++;
        if (obs !== {8'd3, 4'b1001}) $display("FAIL sync_diff: got %h want %h", obs, {8'd3, 4'b1001});
        else n_pass++;
        $display("sync: A=%0d a_valid=%b tracking=%b", A, a_valid, tracking);
    endtask

    task automatic test_midstream_reset();
        step(1, 0, 0, 0);
        step(0, 1, 0, 50);
        step(1, 0, 0, 0);
        n_total++;
        if (obs !== 12'h000) $display("FAIL midreset_clear: got %h want %h", obs, 12'h000);
        else n_pass++;
        step(0, 1, 0, 20);
        n_total++;
        if (a_valid !== 1'b0) $display("FAIL midreset_drop: a_valid got %b want 0", a_valid);
        else n_pass++;
        step(0, 0, 0, 0);
        n_total++;
        if (obs !== {8'd20, 4'b1001}) $display("FAIL midreset_diff: got %h want %h", obs, {8'd20, 4'b1001});
        else n_pass++;
        $display("midreset: A=%0d a_valid=%b", A, a_valid);
    endtask

    task automatic test_gaps();
        logic [N+3:0] e_tab [4] = '{{8'd10, 4'b1001}, {8'd10, 4'b0001}, {8'd10, 4'b0001}, {8'd5, 4'b1001}};
        step(1, 0, 0, 0);
        step(0, 1, 0, 10);
        for (int i = 0; i < 4; i++) begin
            if (i == 2)      step(0, 1, 0, 15);
            else if (i == 3) step(0, 0, 0, 0);
            else             step(0, 0, 0, int'($urandom_range(0, 255)));
            n_total++;
            if (obs !== e_tab[i]) $display("FAIL gaps[%0d]: got %h want %h", i, obs, e_tab[i]);
            else n_pass++;
            $display("gaps: A=%0d a_valid=%b", A, a_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [N+3:0] exp;
        step(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0), int'($urandom_range(0, 255)));
            exp = model_vec();
            n_total++;
            if (obs !== exp) $display("FAIL random[%0d]: got %h want %h", i, obs, exp);
            else n_pass++;
            if (a_valid) $display("random[%0d]: A=%0d borrow=%b overflow=%b", i, A, borrow, overflow);
        end
    endtask

    initial begin
        aclr = 1'b1; s_valid = 1'b0; sync = 1'b0; S = '0;
        test_reset();
        test_stream();
        test_overflow();
        test_sync();
        test_midstream_reset();
        test_gaps();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
